cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Exception/interrupt sequencer that owns the single CP0 write port during exception entry and `eret` return. It samples the exception request and the PC from the MEM stage, plus the live Status, Cause and EPC values from the CP0 register block. It then issues an ordered series of CP0 writes (EPC, Cause, Status) and ends with a one-cycle pipeline flush and redirect PC. It sits between the MEM stage, the pipeline control unit (stall/flush) and the CP0 register block.

## Interface
- `EXC_VECTOR`, default 32'h0000_0020: redirect PC for every exception and interrupt.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `exc_valid_i`  in  1: MEM stage reports a synchronous exception this cycle.
- `exc_code_i`  in  5: ExcCode for that exception.
- `eret_i`  in  1: MEM stage holds an `eret`.
- `pc_i`  in  32: PC of the MEM-stage instruction.
- `in_delayslot_i`  in  1: MEM-stage instruction sits in a branch delay slot.
- `status_i`, `cause_i`, `epc_i`  in  32 each: current CP0 Status, Cause and EPC.
- `cp0_we_o`  out  1: CP0 write enable.
- `cp0_waddr_o`  out  5: CP0 write address (12 = Status, 13 = Cause, 14 = EPC).
- `cp0_wdata_o`  out  32: CP0 write data.
- `stall_o`  out  1: high while the sequence runs; the pipeline holds.
- `flush_o`  out  1: one-cycle pipeline flush pulse.
- `new_pc_o`  out  32: redirect target; valid only while `flush_o` is high, otherwise 0.

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, E_STATUS, REDIRECT. One-hot or binary encoding is allowed.
- Interrupt pending (`irq`): `status_i[0]`=1 (IE), `status_i[1]`=0 (EXL), and `(cause_i[15:8] & status_i[15:8]) != 0`.
- Request acceptance happens only in IDLE. Priority is `irq` > `exc_valid_i` > `eret_i`. Requests presented in any other state are ignored.
- On accepting `irq` or an exception, capture:
  - code: 0 for `irq`, otherwise `exc_code_i`;
  - `bd` = `in_delayslot_i`;
  - `epc_c` = `pc_i` − 4 if `bd`, else `pc_i` (32-bit wrap);
  - `status_c` = `status_i` and `cause_c` = `cause_i`.
  - Next state: W_EPC.
- On accepting `eret`, capture `epc_c` = `epc_i` and `status_c` = `status_i`. Next state: E_STATUS.
- W_EPC: we=1, addr 14, data `epc_c`. Next state: W_CAUSE.
- W_CAUSE: we=1, addr 13, data = {`bd`, `cause_c[30:7]`, code, `cause_c[1:0]`}. Next state: W_STATUS.
- W_STATUS: we=1, addr 12, data = `status_c` | 32'h2 (set EXL). Next state: REDIRECT.
- E_STATUS: we=1, addr 12, data = `status_c` & ~32'h2 (clear EXL). Next state: REDIRECT.
- REDIRECT: `flush_o`=1. `new_pc_o` = `EXC_VECTOR` for exception entry, `epc_c` for eret. Next state: IDLE.
- Outputs are Moore, decoded from the state and capture registers only. In IDLE, `cp0_we_o`, `cp0_waddr_o` and `cp0_wdata_o` are 0.
- `stall_o` = (state != IDLE).

## Timing
- Reset (asynchronous, any state): state goes to IDLE immediately; all capture registers clear to 0; every output is 0. A sequence cut short by reset is abandoned with no completion.
- Exception accepted in cycle T:
  - W_EPC in T+1, W_CAUSE in T+2, W_STATUS in T+3;
  - REDIRECT (`flush_o`) in T+4;
  - back in IDLE at T+5, where a new request can be accepted.
- eret accepted in cycle T: E_STATUS in T+1, REDIRECT in T+2, IDLE at T+3.
- `stall_o` is high T+1..T+4 for an exception and T+1..T+2 for eret. It is low in the acceptance cycle T itself.
- Exactly one CP0 write occurs per cycle, never two.
- Mid-sequence changes to `status_i`, `cause_i`, `epc_i` or `pc_i` have no effect; captured values are used throughout.
- Simultaneous `irq`, `exc_valid_i` and `eret_i`: only `irq` is taken. The exception and the eret are dropped by this block; the pipeline replays them after the flush.
- An eret with `epc_i` = 0 redirects to 0; there is no special case.
- `pc_i` = 0 in a delay slot gives EPC = 32'hFFFF_FFFC.

## Test plan
- Reset mid-W_CAUSE → all outputs 0 in the same cycle. Next request is accepted normally.
- Exception: `exc_code_i`=8, `pc_i`=32'h100, no delay slot, `status_i`=32'h1000_FF01 → writes 14←0x100, 13←code 8 in bits [6:2] with BD=0, 12←0x1000_FF03. Then `flush_o` with `new_pc_o`=0x20 in T+4.
- Delay slot: `pc_i`=32'h204, `in_delayslot_i`=1 → EPC write 0x200 and Cause bit 31 = 1.
- Interrupt: `status_i`=32'h1000_0401, `cause_i[10]`=1, with `exc_valid_i` asserted in the same cycle → Cause ExcCode 0. With EXL=1 instead → no acceptance, `stall_o` stays 0.
- eret: `epc_i`=32'h0000_0480, `status_i`=32'h1000_0003 → write 12←0x1000_0001 in T+1, then `flush_o` with `new_pc_o`=0x480 in T+2.
- Back-to-back: a second `exc_valid_i` held high throughout → ignored during T+1..T+4 and accepted at T+5.

Source files
------------

// File: rtl/cp0_exc_ctrl_if.sv
// Bundle of MEM-stage request, live CP0 state and CP0 write-port / pipeline
// control signals around the exception sequencer.
interface cp0_exc_ctrl_if;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic        eret_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport slave (
    input  exc_valid_i, exc_code_i, eret_i, pc_i, in_delayslot_i,
           status_i, cause_i, epc_i,
    output cp0_we_o, cp0_waddr_o, cp0_wdata_o, stall_o, flush_o, new_pc_o
  );

  modport master (
    output exc_valid_i, exc_code_i, eret_i, pc_i, in_delayslot_i,
           status_i, cause_i, epc_i,
    input  cp0_we_o, cp0_waddr_o, cp0_wdata_o, stall_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/eret sequencer: owns the CP0 write port for EPC/Cause/Status
// updates and ends every sequence with a one-cycle flush and redirect.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting; accepts irq > exception > eret
// S_W_EPC    | writing captured EPC (reg 14)
// S_W_CAUSE  | writing Cause with BD and ExcCode merged in (reg 13)
// S_W_STATUS | writing Status with EXL set (reg 12)
// S_E_STATUS | eret: writing Status with EXL cleared (reg 12)
// S_REDIRECT | flush pulse, redirect to vector or captured EPC
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic            clk,
  input  logic            rst,
  cp0_exc_ctrl_if.slave   bus
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_STATUS,
    S_E_STATUS,
    S_REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic        eret_q, eret_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] status_q, status_d;
  // Only the Cause bits that survive into the rewritten Cause are kept.
  logic [25:0] cause_q, cause_d;

  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;

  logic        irq;
  logic        unused_cause;

  assign irq = bus.status_i[0] && !bus.status_i[1] &&
               ((bus.cause_i[15:8] & bus.status_i[15:8]) != 8'd0);

  assign unused_cause = ^{bus.cause_i[31], bus.cause_i[6:2]};

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    bd_d     = bd_q;
    eret_d   = eret_q;
    epc_d    = epc_q;
    status_d = status_q;
    cause_d  = cause_q;

    case (state_q)
      S_IDLE: begin
        if (irq || bus.exc_valid_i) begin
          code_d   = irq ? 5'd0 : bus.exc_code_i;
          bd_d     = bus.in_delayslot_i;
          eret_d   = 1'b0;
          epc_d    = bus.in_delayslot_i ? (bus.pc_i - 32'd4) : bus.pc_i;
          status_d = bus.status_i;
          cause_d  = {bus.cause_i[30:7], bus.cause_i[1:0]};
          state_d  = S_W_EPC;
        end else if (bus.eret_i) begin
          eret_d   = 1'b1;
          epc_d    = bus.epc_i;
          status_d = bus.status_i;
          state_d  = S_E_STATUS;
        end
      end
      S_W_EPC:    state_d = S_W_CAUSE;
      S_W_CAUSE:  state_d = S_W_STATUS;
      S_W_STATUS: state_d = S_REDIRECT;
      S_E_STATUS: state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    we_d     = 1'b0;
    waddr_d  = 5'd0;
    wdata_d  = 32'd0;
    flush_d  = 1'b0;
    new_pc_d = 32'd0;
    stall_d  = (state_d != S_IDLE);

    case (state_d)
      S_W_EPC: begin
        we_d    = 1'b1;
        waddr_d = ADDR_EPC;
        wdata_d = epc_d;
      end
      S_W_CAUSE: begin
        we_d    = 1'b1;
        waddr_d = ADDR_CAUSE;
        wdata_d = {bd_d, cause_d[25:2], code_d, cause_d[1:0]};
      end
      S_W_STATUS: begin
        we_d    = 1'b1;
        waddr_d = ADDR_STATUS;
        wdata_d = status_d | 32'h0000_0002;
      end
      S_E_STATUS: begin
        we_d    = 1'b1;
        waddr_d = ADDR_STATUS;
        wdata_d = status_d & ~32'h0000_0002;
      end
      S_REDIRECT: begin
        flush_d  = 1'b1;
        new_pc_d = eret_d ? epc_d : EXC_VECTOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      code_q   <= 5'd0;
      bd_q     <= 1'b0;
      eret_q   <= 1'b0;
      epc_q    <= 32'd0;
      status_q <= 32'd0;
      cause_q  <= 26'd0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
      stall_q  <= 1'b0;
      flush_q  <= 1'b0;
      new_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      bd_q     <= bd_d;
      eret_q   <= eret_d;
      epc_q    <= epc_d;
      status_q <= status_d;
      cause_q  <= cause_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign bus.cp0_we_o    = we_q;
  assign bus.cp0_waddr_o = waddr_q;
  assign bus.cp0_wdata_o = wdata_q;
  assign bus.stall_o     = stall_q;
  assign bus.flush_o     = flush_q;
  assign bus.new_pc_o    = new_pc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: a queue-based model of the expected output stream
// checked every cycle, plus hand-computed literal checks of key cycles.
module tb_cp0_exc_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  bit   run_cmp;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        flush;
    logic [31:0] npc;
  } exp_t;

  exp_t exp_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endfunction

  // Model: a request accepted while idle schedules the whole output stream.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else begin
      logic        ie, exl, pend;
      logic [31:0] st, ca, epc, cw;
      logic [4:0]  code;
      st   = bus.status_i;
      ca   = bus.cause_i;
      ie   = st[0];
      exl  = st[1];
      pend = (((ca >> 8) & (st >> 8) & 32'hFF) != 0);
      if ((ie && !exl && pend) || bus.exc_valid_i) begin
        code = (ie && !exl && pend) ? 5'd0 : bus.exc_code_i;
        epc  = bus.pc_i - (bus.in_delayslot_i ? 32'd4 : 32'd0);
        cw   = (ca & 32'h7FFF_FF83) | ({31'd0, bus.in_delayslot_i} << 31) |
               ({27'd0, code} << 2);
        exp_q.push_back('{1'b1, 5'd14, epc, 1'b1, 1'b0, 32'd0});
        exp_q.push_back('{1'b1, 5'd13, cw, 1'b1, 1'b0, 32'd0});
        exp_q.push_back('{1'b1, 5'd12, st | 32'd2, 1'b1, 1'b0, 32'd0});
        exp_q.push_back('{1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'h20});
      end else if (bus.eret_i) begin
        exp_q.push_back('{1'b1, 5'd12, st & ~32'd2, 1'b1, 1'b0, 32'd0});
        exp_q.push_back('{1'b0, 5'd0, 32'd0, 1'b1, 1'b1, bus.epc_i});
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      exp_t e, a;
      e = (exp_q.size() != 0) ? exp_q[0] : '0;
      a = '{bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_wdata_o,
            bus.stall_o, bus.flush_o, bus.new_pc_o};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL cycle_model @%0t: got we=%0b addr=%0d data=0x%08h stall=%0b flush=%0b npc=0x%08h expected we=%0b addr=%0d data=0x%08h stall=%0b flush=%0b npc=0x%08h",
                    $time, a.we, a.addr, a.data, a.stall, a.flush, a.npc,
                    e.we, e.addr, e.data, e.stall, e.flush, e.npc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_req();
    bus.exc_valid_i    = 1'b0;
    bus.exc_code_i     = 5'd0;
    bus.eret_i         = 1'b0;
    bus.in_delayslot_i = 1'b0;
  endtask

  task automatic set_ctx(logic [31:0] pc, logic bd, logic [31:0] st,
                         logic [31:0] ca, logic [31:0] epc);
    bus.pc_i           = pc;
    bus.in_delayslot_i = bd;
    bus.status_i       = st;
    bus.cause_i        = ca;
    bus.epc_i          = epc;
  endtask

  task automatic chk_write(string name, logic [4:0] addr, logic [31:0] data);
    chk({name, "_we"}, {31'd0, bus.cp0_we_o}, 32'd1);
    chk({name, "_addr"}, {27'd0, bus.cp0_waddr_o}, {27'd0, addr});
    chk({name, "_data"}, bus.cp0_wdata_o, data);
  endtask

  task automatic chk_idle_outs(string name);
    chk({name, "_outs"},
        {29'd0, bus.cp0_we_o, bus.stall_o, bus.flush_o} |
        {27'd0, bus.cp0_waddr_o} | bus.cp0_wdata_o | bus.new_pc_o, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    run_cmp  = 1'b0;
    rst      = 1'b1;
    clear_req();
    set_ctx(32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    repeat (3) tick();
    chk_idle_outs("reset_state");
    rst = 1'b0;
    run_cmp = 1'b1;
    tick();

    // Plain exception, code 8
    set_ctx(32'h100, 1'b0, 32'h1000_FF01, 32'd0, 32'd0);
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i  = 5'd8;
    chk("accept_cycle_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    clear_req();
    set_ctx(32'h999, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h5);
    chk_write("exc_epc", 5'd14, 32'h100);
    tick();
    chk_write("exc_cause", 5'd13, 32'h0000_0020);
    tick();
    chk_write("exc_status", 5'd12, 32'h1000_FF03);
    tick();
    chk("exc_flush", {31'd0, bus.flush_o}, 32'd1);
    chk("exc_newpc", bus.new_pc_o, 32'h20);
    chk("exc_stall_redirect", {31'd0, bus.stall_o}, 32'd1);
    tick();
    chk_idle_outs("exc_back_idle");

    // Delay slot
    set_ctx(32'h204, 1'b1, 32'h1000_0001, 32'd0, 32'd0);
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i  = 5'd4;
    tick();
    clear_req();
    chk_write("bd_epc", 5'd14, 32'h200);
    tick();
    chk_write("bd_cause", 5'd13, 32'h8000_0010);
    repeat (4) tick();

    // Interrupt beats a simultaneous exception and eret
    set_ctx(32'h300, 1'b0, 32'h1000_0401, 32'h0000_0400, 32'h44);
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i  = 5'd12;
    bus.eret_i      = 1'b1;
    tick();
    clear_req();
    bus.cause_i = 32'd0;
    chk_write("irq_epc", 5'd14, 32'h300);
    tick();
    chk_write("irq_cause", 5'd13, 32'h0000_0400);
    tick();
    chk_write("irq_status", 5'd12, 32'h1000_0403);
    tick();
    chk("irq_newpc", bus.new_pc_o, 32'h20);
    tick();

    // Interrupt masked by EXL
    set_ctx(32'h300, 1'b0, 32'h1000_0403, 32'h0000_0400, 32'h0);
    tick();
    chk("exl_no_stall_a", {31'd0, bus.stall_o}, 32'd0);
    tick();
    chk("exl_no_stall_b", {31'd0, bus.stall_o}, 32'd0);
    set_ctx(32'h0, 1'b0, 32'h0, 32'h0, 32'h0);

    // eret
    set_ctx(32'h0, 1'b0, 32'h1000_0003, 32'd0, 32'h0000_0480);
    bus.eret_i = 1'b1;
    tick();
    clear_req();
    bus.epc_i = 32'h1234;
    chk_write("eret_status", 5'd12, 32'h1000_0001);
    tick();
    chk("eret_flush", {31'd0, bus.flush_o}, 32'd1);
    chk("eret_newpc", bus.new_pc_o, 32'h480);
    tick();
    chk_idle_outs("eret_back_idle");

    // eret to address 0
    set_ctx(32'h0, 1'b0, 32'h0000_0002, 32'd0, 32'h0);
    bus.eret_i = 1'b1;
    tick();
    clear_req();
    tick();
    chk("eret0_newpc", bus.new_pc_o, 32'h0);
    chk("eret0_flush", {31'd0, bus.flush_o}, 32'd1);
    tick();

    // pc 0 in a delay slot wraps
    set_ctx(32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i  = 5'd10;
    tick();
    clear_req();
    chk_write("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    repeat (4) tick();

    // Back-to-back: request held high the whole time
    set_ctx(32'h500, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i  = 5'd5;
    tick();
    bus.pc_i = 32'h600;
    repeat (3) tick();
    chk("b2b_redirect", {31'd0, bus.flush_o}, 32'd1);
    tick();
    chk("b2b_gap_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    clear_req();
    chk_write("b2b_second_epc", 5'd14, 32'h600);
    repeat (4) tick();

    // Reset in the middle of W_CAUSE
    set_ctx(32'h700, 1'b0, 32'h1, 32'h0, 32'h0);
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i  = 5'd9;
    tick();
    clear_req();
    tick();
    chk("pre_reset_in_cause", {27'd0, bus.cp0_waddr_o}, 32'd13);
    #1 rst = 1'b1;
    #1;
    chk_idle_outs("reset_mid_cause");
    tick();
    chk_idle_outs("reset_held");
    rst = 1'b0;
    tick();
    chk_idle_outs("post_reset_idle");
    set_ctx(32'h800, 1'b0, 32'h1, 32'h0, 32'h0);
    bus.exc_valid_i = 1'b1;
    bus.exc_code_i  = 5'd3;
    tick();
    clear_req();
    chk_write("post_reset_epc", 5'd14, 32'h800);
    tick();
    chk_write("post_reset_cause", 5'd13, 32'h0000_000C);
    repeat (5) tick();

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
